// File: rtl/pingpong_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pingpong_line_buffer
//  Purpose  : Double-banked (ping-pong) pixel line buffer for the display
//             path. The write side fills one bank while the read side drains
//             the other. Each bank is either EMPTY or FULL and remembers the
//             length of the line it holds. A bank is handed to the reader
//             when the line ends (WrLast or DEPTH pixels). It is handed back
//             to the writer when the last pixel of that line has been read.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        rising-edge clock
//    rst_i        synchronous active-high reset
//    wr_en_i      write request
//    wr_data_i    pixel to write, channel 0 in the MS slice
//    wr_last_i    qualifies wr_en_i: this pixel ends the line
//    wr_ready_o   write bank is empty, so a write is accepted
//    wr_err_o     1-cycle pulse one cycle after a write that was dropped
//    rd_en_i      read request
//    rd_avail_o   read bank holds a complete line
//    rd_valid_o   rd_data_o carries a pixel this cycle (1-cycle latency)
//    rd_data_o    pixel read; holds its value between reads
//    rd_last_o    with rd_valid_o: last pixel of the line
//    mirror_i     horizontal flip for the line (only with LINEBUF_MIRROR_EN)
//  Build option
//    LINEBUF_MIRROR_EN : adds mirror_i. It is sampled on the first read of
//                        a line and held for the rest of that line.
// ============================================================================
module pingpong_line_buffer #(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 100,
  parameter int AW     = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [NUM_CH*CH_W-1:0] wr_data_i,
  input  logic                   wr_last_i,
  output logic                   wr_ready_o,
  output logic                   wr_err_o,
  input  logic                   rd_en_i,
  output logic                   rd_avail_o,
  output logic                   rd_valid_o,
  output logic [NUM_CH*CH_W-1:0] rd_data_o,
  output logic                   rd_last_o
`ifdef LINEBUF_MIRROR_EN
  ,
  input  logic                   mirror_i
`endif
);

  localparam int            c_DW        = NUM_CH * CH_W;
  localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);
  localparam logic [AW:0]   c_LEN_ONE   = (AW + 1)'(1);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  bank_state_e     state_q [2];
  bank_state_e     state_d [2];
  logic [AW:0]     len_q   [2];
  logic [AW:0]     len_d   [2];
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [AW-1:0]   wptr_q,  wptr_d;
  logic [AW-1:0]   rptr_q,  rptr_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q,  rd_last_d;
  logic [c_DW-1:0] rd_data_q,  rd_data_d;
  logic            wr_err_q,   wr_err_d;

  // Pixel storage. It is not reset. Bank state guards every read.
  logic [c_DW-1:0] mem_q [2][DEPTH];

  logic            w_wr_acc;
  logic            w_wr_end;
  logic            w_rd_acc;
  logic            w_rd_end;
  logic [AW:0]     w_len_m1;
  logic [AW-1:0]   w_rd_addr;

  assign wr_ready_o = (state_q[wbank_q] == BANK_EMPTY);
  assign rd_avail_o = (state_q[rbank_q] == BANK_FULL);
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_last_q;
  assign rd_data_o  = rd_data_q;
  assign wr_err_o   = wr_err_q;

  assign w_wr_acc = wr_en_i & wr_ready_o;
  assign w_wr_end = wr_last_i | (wptr_q == c_LAST_ADDR);
  assign w_rd_acc = rd_en_i & rd_avail_o;
  assign w_len_m1 = len_q[rbank_q] - c_LEN_ONE;
  assign w_rd_end = ({1'b0, rptr_q} == w_len_m1);

`ifdef LINEBUF_MIRROR_EN
  logic mirror_q, mirror_d;
  logic w_mirror_line;

  // Use the live input on the first pixel of a line and the latched value
  // afterwards, so the whole line is read in one direction.
  assign w_mirror_line = (rptr_q == '0) ? mirror_i : mirror_q;
  // len-1 is always below 2**AW, so the low AW bits are enough for the address.
  assign w_rd_addr     = w_mirror_line ? (w_len_m1[AW-1:0] - rptr_q) : rptr_q;
`else
  assign w_rd_addr     = rptr_q;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = w_rd_acc;
    rd_last_d  = w_rd_acc & w_rd_end;
    rd_data_d  = rd_data_q;
    wr_err_d   = wr_en_i & ~wr_ready_o;
`ifdef LINEBUF_MIRROR_EN
    mirror_d   = mirror_q;
`endif

    // The write bank is EMPTY and the read bank is FULL, so the two sides
    // never touch the same bank. Both updates can apply in the same cycle.
    if (w_wr_acc) begin
      if (w_wr_end) begin
        state_d[wbank_q] = BANK_FULL;
        len_d[wbank_q]   = {1'b0, wptr_q} + c_LEN_ONE;
        wptr_d           = '0;
        wbank_d          = ~wbank_q;
      end else begin
        wptr_d           = wptr_q + c_PTR_ONE;
      end
    end

    if (w_rd_acc) begin
      rd_data_d = mem_q[rbank_q][w_rd_addr];
`ifdef LINEBUF_MIRROR_EN
      mirror_d  = w_mirror_line;
`endif
      if (w_rd_end) begin
        state_d[rbank_q] = BANK_EMPTY;
        rptr_d           = '0;
        rbank_d          = ~rbank_q;
      end else begin
        rptr_d           = rptr_q + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q[0] <= BANK_EMPTY;
      state_q[1] <= BANK_EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
`ifdef LINEBUF_MIRROR_EN
      mirror_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= wr_err_d;
`ifdef LINEBUF_MIRROR_EN
      mirror_q   <= mirror_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      mem_q[wbank_q][wptr_q] <= wr_data_i;
    end
  end

endmodule
`default_nettype wire
